line_packer_128to512: RTL and testbench

- Downstream neighbour of the 4:1 128-bit output mux in the harp2 kernel.
- Takes the 128-bit word stream selected by the mux and packs four consecutive words into one 512-bit line for the host write path.
- A stream ends on in_last. A partial final line is zero-padded and flagged with its valid word count.
- Valid/ready on both sides; full throughput (1 word/cycle) while downstream is ready.

---
 rtl/harp2_pkg.sv | 14 +
 rtl/line_packer_128to512.sv | 141 ++++++++++++++
 tb/tb_line_packer_128to512.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/harp2_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the harp2 kernel host write path.
package harp2_pkg;

  // Host line width and kernel word width.
  localparam int LINE_W = 512;
  localparam int WORD_W = 128;

  // Width of a "valid word count" field able to hold 1..lanes.
  function automatic int lanes_to_nwords_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/line_packer_128to512.sv
`timescale 1ns/1ps
// Packs consecutive 128-bit words from the 4:1 output mux into 512-bit host
// lines. A stream closes on in_last; a short final line is zero-padded and
// tagged with its valid word count. Full throughput while the consumer is ready.
module line_packer_128to512
  import harp2_pkg::*;
#(
  parameter int  IN_W  = WORD_W,
  parameter int  LANES = LINE_W / WORD_W,
  parameter int  CNT_W = 32,
  localparam int IDX_W = $clog2(LANES),
  localparam int NW_W  = lanes_to_nwords_w(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [IN_W*LANES-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [NW_W-1:0]       out_nwords,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      line_cnt
);

  localparam int                OUT_W    = IN_W * LANES;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

  // Next lane to fill and the lanes collected so far. The top lane never needs
  // storage: a word landing there always closes the line straight away.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  acc_q [LANES-1];
  logic [IN_W-1:0]  acc_d [LANES-1];

  // Output register.
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [NW_W-1:0]  out_nwords_q, out_nwords_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

  logic             accept;
  logic             complete;
  logic             handoff;
  logic [OUT_W-1:0] line_c;

  // The output register can take a new line when it is empty or being drained.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  // A word closes the line when it fills the top lane or ends the stream.
  assign complete = accept & (in_last | (idx_q == LAST_IDX));
  assign handoff  = out_valid_q & out_ready;

  // Line image for a completing accept: stored lanes below idx, the incoming
  // word at idx, zero padding above it.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi < LANES - 1) begin : g_stored
      assign line_c[gi*IN_W +: IN_W] =
        (IDX_W'(gi) < idx_q)  ? acc_q[gi] :
        (IDX_W'(gi) == idx_q) ? in_data   : '0;
    end else begin : g_top
      assign line_c[gi*IN_W +: IN_W] = (IDX_W'(gi) == idx_q) ? in_data : '0;
    end
  end

  // Accumulation lanes and fill index: store on partial accepts, wipe on close.
  always_comb begin
    idx_d = idx_q;
    for (int k = 0; k < LANES - 1; k++) begin
      acc_d[k] = acc_q[k];
    end
    if (complete) begin
      idx_d = '0;
      for (int k = 0; k < LANES - 1; k++) begin
        acc_d[k] = '0;
      end
    end else if (accept) begin
      idx_d = idx_q + IDX_W'(1);
      for (int k = 0; k < LANES - 1; k++) begin
        if (idx_q == IDX_W'(k)) begin
          acc_d[k] = in_data;
        end
      end
    end
  end

  // Output register: reload on a closed line (even while handing off the
  // previous one), otherwise drop valid once the consumer has taken the line.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_nwords_d = out_nwords_q;
    line_cnt_d   = line_cnt_q;
    if (complete) begin
      out_data_d   = line_c;
      out_valid_d  = 1'b1;
      out_last_d   = in_last;
      out_nwords_d = {1'b0, idx_q} + NW_W'(1);
    end else if (handoff) begin
      out_valid_d  = 1'b0;
    end
    if (handoff) begin
      line_cnt_d = line_cnt_q + CNT_W'(1);
    end
  end

  // State update; reset drops any partial line and empties the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_nwords_q <= '0;
      line_cnt_q   <= '0;
      for (int k = 0; k < LANES - 1; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      idx_q        <= idx_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_nwords_q <= out_nwords_d;
      line_cnt_q   <= line_cnt_d;
      for (int k = 0; k < LANES - 1; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_nwords = out_nwords_q;
  assign line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_line_packer_128to512.sv
`timescale 1ns/1ps
// Self-checking bench for line_packer_128to512: directed scenarios plus a
// randomized run, all compared against a queue-based line model.
module tb_line_packer_128to512;
  import harp2_pkg::*;

  localparam int IN_W  = WORD_W;
  localparam int LANES = 4;
  localparam int CNT_W = 32;
  localparam int NW_W  = lanes_to_nwords_w(LANES);
  localparam int OUT_W = IN_W * LANES;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
    logic [NW_W-1:0]  nw;
  } line_t;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [NW_W-1:0]  out_nwords;
  logic             out_ready;
  logic [CNT_W-1:0] line_cnt;

  int total = 0;
  int bad   = 0;
  line_t           exp_q[$];
  line_t           obs_q[$];
  logic [IN_W-1:0] cur_q[$];
  int              exp_total = 0;
  logic            fired;

  line_packer_128to512 #(.IN_W(IN_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_nwords(out_nwords), .out_ready(out_ready), .line_cnt(line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IN_W-1:0] mkw(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {32'hC0DE_0000 | v, ~v, v ^ 32'h5A5A_5A5A, v};
  endfunction

  function automatic logic [IN_W-1:0] rndw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: words are grouped into lines of LANES in arrival order; a stream
  // end closes the group early and the missing lanes read as zero.
  task automatic model_push(input logic [IN_W-1:0] w, input logic l);
    line_t ln;
    cur_q.push_back(w);
    if (cur_q.size() == LANES || l) begin
      ln.data = '0;
      for (int k = 0; k < cur_q.size(); k++) ln.data[k*IN_W +: IN_W] = cur_q[k];
      ln.nw   = NW_W'(cur_q.size());
      ln.last = l;
      exp_q.push_back(ln);
      exp_total++;
      cur_q.delete();
    end
  endtask

  // One clock: sample handshakes just before the rising edge, then return at
  // the following falling edge where the next stimulus is driven.
  task automatic step();
    line_t ln;
    #3;
    fired = in_valid && in_ready;
    if (out_valid && out_ready) begin
      ln.data = out_data; ln.last = out_last; ln.nw = out_nwords;
      obs_q.push_back(ln);
      $display("handoff #%0d nwords=%0d last=%b lane0=%h", obs_q.size(), out_nwords, out_last, out_data[IN_W-1:0]);
    end
    if (fired) model_push(in_data, in_last);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [IN_W-1:0] w, input logic l, input logic rdy);
    in_valid = 1'b1; in_data = w; in_last = l; out_ready = rdy;
  endtask

  task automatic drain();
    in_valid = 1'b0; in_data = rndw(); in_last = 1'($urandom); out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
    total++; if (out_nwords !== '0) begin bad++; $display("FAIL reset_nwords got=%0d want=0", out_nwords); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (line_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", line_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_full_lines();
    logic [OUT_W-1:0] want;
    clear_queues();
    want = {mkw(4), mkw(3), mkw(2), mkw(1)};
    for (int i = 0; i < 8; i++) begin
      drive(mkw(i + 1), i == 7, 1'b1);
      step();
      if (i == 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b want=0", out_valid); end
      end
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== want || out_nwords !== NW_W'(4) || out_last !== 1'b0) begin
          bad++; $display("FAIL full_line1 got=%b/%h/%0d/%b want=1/%h/4/0", out_valid, out_data, out_nwords, out_last, want);
        end
      end
    end
    drain();
    total++; if (obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL full_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL full_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
    total++; if (line_cnt !== CNT_W'(exp_total)) begin bad++; $display("FAIL full_cnt got=%0d want=%0d", line_cnt, exp_total); end
  endtask

  task automatic test_partial();
    logic [IN_W-1:0] a, b, c;
    logic [OUT_W-1:0] want;
    clear_queues();
    a = rndw(); b = rndw(); c = rndw();
    want = {{IN_W{1'b0}}, c, b, a};
    drive(a, 1'b0, 1'b1); step();
    drive(b, 1'b0, 1'b1); step();
    drive(c, 1'b1, 1'b1); step();
    total++;
    if (out_valid !== 1'b1 || out_data !== want || out_nwords !== NW_W'(3) || out_last !== 1'b1) begin
      bad++; $display("FAIL partial_line got=%b/%h/%0d/%b want=1/%h/3/1", out_valid, out_data, out_nwords, out_last, want);
    end
    drain();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL partial_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL partial_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
  endtask

  task automatic test_single();
    logic [IN_W-1:0] d;
    logic [OUT_W-1:0] want;
    d = rndw();
    want = {{(3*IN_W){1'b0}}, d};
    drive(d, 1'b1, 1'b1); step();
    total++;
    if (out_valid !== 1'b1 || out_data !== want || out_nwords !== NW_W'(1) || out_last !== 1'b1) begin
      bad++; $display("FAIL single_line got=%b/%h/%0d/%b want=1/%h/1/1", out_valid, out_data, out_nwords, out_last, want);
    end
    drain();
    total++; if (line_cnt !== CNT_W'(exp_total)) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", line_cnt, exp_total); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] want;
    clear_queues();
    want = {mkw(16'h13), mkw(16'h12), mkw(16'h11), mkw(16'h10)};
    for (int i = 0; i < 4; i++) begin
      drive(mkw(16'h10 + i), 1'b0, 1'b0); step();
    end
    drive(mkw(16'h14), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc%0d got=%b want=0", c, in_ready); end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== want || out_nwords !== NW_W'(4) || out_last !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc%0d got=%b/%h/%0d want=1/%h/4", c, out_valid, out_data, out_nwords, want);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    step();
    for (int i = 5; i < 8; i++) begin
      drive(mkw(16'h10 + i), i == 7, 1'b1); step();
    end
    drain();
    total++; if (obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
  endtask

  task automatic test_simultaneous();
    int base;
    logic [IN_W-1:0] w[7];
    clear_queues();
    base = exp_total;
    for (int i = 0; i < 7; i++) w[i] = rndw();
    // A full line followed by three one-word streams: every cycle from the
    // fifth word on hands off one line and closes the next.
    for (int i = 0; i < 7; i++) begin
      drive(w[i], i >= 4, 1'b1);
      step();
      if (i >= 4) begin
        total++;
        if (out_valid !== 1'b1 || line_cnt !== CNT_W'(base + i - 3)) begin
          bad++; $display("FAIL simul_cyc%0d got=%b/%0d want=1/%0d", i, out_valid, line_cnt, base + i - 3);
        end
      end
      if (i == 4) begin
        total++;
        if (out_data !== {{(3*IN_W){1'b0}}, w[4]} || out_nwords !== NW_W'(1)) begin
          bad++; $display("FAIL simul_reload got=%h/%0d want=%h/1", out_data, out_nwords, w[4]);
        end
      end
    end
    drain();
    total++; if (obs_q.size() != 4 || exp_q.size() != 4) begin bad++; $display("FAIL simul_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL simul_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
    total++; if (line_cnt !== CNT_W'(base + 4)) begin bad++; $display("FAIL simul_cnt got=%0d want=%0d", line_cnt, base + 4); end
  endtask

  task automatic test_reset_mid_line();
    logic [IN_W-1:0] e[4];
    logic [OUT_W-1:0] want;
    clear_queues();
    drive(rndw(), 1'b0, 1'b1); step();
    drive(rndw(), 1'b0, 1'b1); step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_nwords !== '0 || out_data !== '0 || line_cnt !== '0) begin
      bad++; $display("FAIL rst_async got=%b/%b/%0d/%h/%0d want=0/0/0/0/0", out_valid, out_last, out_nwords, out_data, line_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur_q.delete(); clear_queues(); exp_total = 0;
    for (int i = 0; i < 4; i++) e[i] = rndw();
    want = {e[3], e[2], e[1], e[0]};
    for (int i = 0; i < 4; i++) begin
      drive(e[i], i == 3, 1'b0); step();
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== want || out_nwords !== NW_W'(4) || line_cnt !== '0) begin
      bad++; $display("FAIL rst_post_line got=%b/%h/%0d/%0d want=1/%h/4/0", out_valid, out_data, out_nwords, line_cnt, want);
    end
    drain();
    total++; if (line_cnt !== CNT_W'(1)) begin bad++; $display("FAIL rst_post_cnt got=%0d want=1", line_cnt); end
    total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL rst_count got=%0d want=1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rst_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
  endtask

  task automatic test_random();
    logic [IN_W-1:0] sd[$];
    logic            sl[$];
    int ptr = 0;
    int cyc = 0;
    int len;
    clear_queues();
    while (sd.size() < 240) begin
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        sd.push_back(rndw());
        sl.push_back(j == len - 1);
      end
    end
    while ((ptr < sd.size() || out_valid) && cyc < 5000) begin
      if (ptr < sd.size() && $urandom_range(0, 99) < 75) begin
        in_valid = 1'b1; in_data = sd[ptr]; in_last = sl[ptr];
      end else begin
        in_valid = 1'b0; in_data = rndw(); in_last = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      step();
      if (fired) ptr++;
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (cyc >= 5000) begin bad++; $display("FAIL rand_timeout got=%0d words sent want=%0d", ptr, sd.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_line%0d got=%h/%b/%0d want=%h/%b/%0d", i, obs_q[i].data, obs_q[i].last, obs_q[i].nw, exp_q[i].data, exp_q[i].last, exp_q[i].nw);
      end
    end
    total++; if (line_cnt !== CNT_W'(exp_total)) begin bad++; $display("FAIL rand_cnt got=%0d want=%0d", line_cnt, exp_total); end
  endtask

  initial begin
    test_reset();
    test_full_lines();
    test_partial();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_line();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
